// File: rtl/text_video_pkg.sv
// Shared timing constants, widths and pipeline stage payload for the text-mode
// scan-out engine (640x480 @ 800x525 total, 80x60 cells of 8x8 glyphs).
package text_video_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_H     = 8;
  localparam int unsigned COLS        = H_ACTIVE / GLYPH_W;
  localparam int unsigned ROWS        = V_ACTIVE / GLYPH_H;
  localparam int unsigned TEXT_ADDR_W = 13;
  localparam int unsigned CHAR_W      = 7;
  localparam int unsigned HCNT_W      = 10;
  localparam int unsigned VCNT_W      = 10;

  // Per-pixel side information carried down the fetch pipeline.
  typedef struct packed {
    logic [2:0] hcol;
    logic [2:0] vrow;
    logic       active;
    logic       hs;
    logic       vs;
    logic       sof;
  } stage_t;

  localparam stage_t STAGE_RST = '{hcol: 3'd0, vrow: 3'd0, active: 1'b0,
                                   hs: 1'b1, vs: 1'b1, sof: 1'b0};

  // row*80 + col without a multiplier: 80 = 64 + 16.
  function automatic logic [TEXT_ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                       input logic [6:0] col);
    logic [TEXT_ADDR_W-1:0] r;
    r = TEXT_ADDR_W'(row);
    return (r << 6) + (r << 4) + TEXT_ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters plus raw (unpipelined) active/sync/start-of-frame flags.
// Ports: clk, rst (sync, active-high), pix_ce (advance enable),
//        hcount_q/vcount_q (current raster position), active_c, hs_c, vs_c
//        (active-low syncs), sof_c (position is 0,0).
module vga_timing
  import text_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  output logic [HCNT_W-1:0] hcount_q,
  output logic [VCNT_W-1:0] vcount_q,
  output logic              active_c,
  output logic              hs_c,
  output logic              vs_c,
  output logic              sof_c
);

  logic [HCNT_W-1:0] hcount_d;
  logic [VCNT_W-1:0] vcount_d;

  // Raster advance: wrap horizontal at line end, vertical at frame end.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce) begin
      if (hcount_q == HCNT_W'(H_TOTAL - 1)) begin
        hcount_d = '0;
        if (vcount_q == VCNT_W'(V_TOTAL - 1)) vcount_d = '0;
        else                                  vcount_d = vcount_q + VCNT_W'(1);
      end else begin
        hcount_d = hcount_q + HCNT_W'(1);
      end
    end
  end

  // Raw flags for the current position.
  always_comb begin
    active_c = (hcount_q < HCNT_W'(H_ACTIVE)) && (vcount_q < VCNT_W'(V_ACTIVE));
    hs_c     = !((hcount_q >= HCNT_W'(H_SYNC_START)) && (hcount_q <= HCNT_W'(H_SYNC_END)));
    vs_c     = !((vcount_q >= VCNT_W'(V_SYNC_START)) && (vcount_q <= VCNT_W'(V_SYNC_END)));
    sof_c    = (hcount_q == '0) && (vcount_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode scan-out: raster timing, text buffer fetch, glyph lookup and
// 1-bit pixel serialisation with sync/active aligned 3 pix_ce ticks behind
// the raster counters.
// Ports: clk, rst (sync, active-high), pix_ce, text_addr -> text buffer,
//        text_data <- text buffer (one pix_ce tick later), char_code -> glyph
//        ROM (pass-through), glyph_data <- glyph ROM (combinational),
//        pixel, video_active, hsync/vsync (active-low), frame_start.
// Optional build macro TEXT_CURSOR_EN adds cursor_col/cursor_row and a
// blinking inverted-cell cursor.
module text_pixel_gen
  import text_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [12:0] text_addr,
  input  logic [6:0]  text_data,
  output logic [6:0]  char_code,
  input  logic [63:0] glyph_data,
  output logic        pixel,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef TEXT_CURSOR_EN
  ,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row
`endif
);

  logic [HCNT_W-1:0] hcount_q;
  logic [VCNT_W-1:0] vcount_q;
  logic active_c, hs_c, vs_c, sof_c;

  vga_timing u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_ce   (pix_ce),
    .hcount_q (hcount_q),
    .vcount_q (vcount_q),
    .active_c (active_c),
    .hs_c     (hs_c),
    .vs_c     (vs_c),
    .sof_c    (sof_c)
  );

  stage_t s1_q, s1_d, s2_q, s2_d;
  logic [TEXT_ADDR_W-1:0] text_addr_q, text_addr_d;
  logic pixel_q, pixel_d, video_active_q, video_active_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
  logic [5:0] row_c;
  logic [6:0] col_c;
  logic glyph_bit_c;
  logic cur_inv_c;

  assign row_c = vcount_q[8:3];
  assign col_c = hcount_q[9:3];

  // The RAM read data lines up with s2_q, so the glyph arrives in that stage.
  assign char_code = text_data;

  // Bit index 63 - 8*vrow - hcol equals {~vrow, ~hcol}.
  assign glyph_bit_c = glyph_data[{~s2_q.vrow, ~s2_q.hcol}];

`ifdef TEXT_CURSOR_EN
  logic cur_hit1_q, cur_hit1_d, cur_hit2_q, cur_hit2_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic [4:0] frame_idx_c;

  // Counter holds frames started, so the current frame index is one less.
  always_comb begin
    cur_hit1_d  = cur_hit1_q;
    cur_hit2_d  = cur_hit2_q;
    frame_cnt_d = frame_cnt_q;
    frame_idx_c = frame_cnt_q - 5'd1;
    if (pix_ce) begin
      cur_hit1_d = active_c && (row_c == cursor_row) && (col_c == cursor_col);
      cur_hit2_d = cur_hit1_q;
      if (s2_q.sof) frame_cnt_d = frame_cnt_q + 5'd1;
    end
    cur_inv_c = cur_hit2_q & frame_idx_c[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_hit1_q  <= 1'b0;
      cur_hit2_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cur_hit1_q  <= cur_hit1_d;
      cur_hit2_q  <= cur_hit2_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign cur_inv_c = 1'b0;
`endif

  // S1 address/side-info capture, S2 delay, S3 pixel and sync registration.
  always_comb begin
    s1_d           = s1_q;
    s2_d           = s2_q;
    text_addr_d    = text_addr_q;
    pixel_d        = pixel_q;
    video_active_d = video_active_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    frame_start_d  = 1'b0;  // pulse only on the ce clk that registers (0,0)
    if (pix_ce) begin
      s1_d           = '{hcol: hcount_q[2:0], vrow: vcount_q[2:0], active: active_c,
                         hs: hs_c, vs: vs_c, sof: sof_c};
      text_addr_d    = active_c ? cell_addr(row_c, col_c) : '0;
      s2_d           = s1_q;
      pixel_d        = s2_q.active & (glyph_bit_c ^ cur_inv_c);
      video_active_d = s2_q.active;
      hsync_d        = s2_q.hs;
      vsync_d        = s2_q.vs;
      frame_start_d  = s2_q.sof;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q           <= STAGE_RST;
      s2_q           <= STAGE_RST;
      text_addr_q    <= '0;
      pixel_q        <= 1'b0;
      video_active_q <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      text_addr_q    <= text_addr_d;
      pixel_q        <= pixel_d;
      video_active_q <= video_active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign text_addr    = text_addr_q;
  assign pixel        = pixel_q;
  assign video_active = video_active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen: reset state, pipeline latency, glyph
// serialisation, hsync/active boundaries, text address generation, mid-run
// reset and a 1-in-4 pixel clock enable.
module tb_text_pixel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [12:0] text_addr;
  logic [6:0]  text_data = 7'd0;
  logic [6:0]  char_code;
  logic [63:0] glyph_data;
  logic        pixel, video_active, hsync, vsync, frame_start;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick     = 0;
  int   div      = 1;
  logic addr_mode = 1'b0;

  localparam logic [63:0] GLYPH_A = 64'h3C66_667E_6666_6600;

  always #5 clk = ~clk;

  text_pixel_gen dut (
    .clk          (clk),
    .rst          (rst),
    .pix_ce       (pix_ce),
    .text_addr    (text_addr),
    .text_data    (text_data),
    .char_code    (char_code),
    .glyph_data   (glyph_data),
    .pixel        (pixel),
    .video_active (video_active),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start)
  );

  // Text buffer: one pix_ce tick read latency.
  always @(posedge clk) if (pix_ce) text_data <= addr_mode ? text_addr[6:0] : 7'h41;

  // Glyph ROM: 'A' and blank for everything else.
  always_comb glyph_data = (char_code == 7'h41) ? GLYPH_A : 64'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, tick);
    end
  endtask

  task automatic step();
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    tick++;
    if (div > 1) pix_ce = 1'b0;
  endtask

  task automatic idle();
    for (int i = 1; i < div; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to(input int k);
    while (tick < k) begin
      idle();
      step();
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_pixel"}, 32'(pixel), 32'd0);
    check_eq({pfx, "_active"}, 32'(video_active), 32'd0);
    check_eq({pfx, "_hsync"}, 32'(hsync), 32'd1);
    check_eq({pfx, "_vsync"}, 32'(vsync), 32'd1);
    check_eq({pfx, "_fstart"}, 32'(frame_start), 32'd0);
    check_eq({pfx, "_addr"}, 32'(text_addr), 32'd0);
  endtask

  initial begin
    logic [7:0] row0;
    row0 = 8'h3C;

    // Power-up reset.
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    tick = 0;

    // Output after tick k reflects raster position k-3; text_addr reflects k-1.
    run_to(1);
    check_eq("fs_t1", 32'(frame_start), 32'd0);
    check_eq("va_t1", 32'(video_active), 32'd0);
    run_to(2);
    check_eq("fs_t2", 32'(frame_start), 32'd0);
    run_to(3);
    check_eq("fs_t3", 32'(frame_start), 32'd1);
    check_eq("va_t3", 32'(video_active), 32'd1);
    check_eq("px_r0_x0", 32'(pixel), 32'd0);
    for (int x = 1; x < 8; x++) begin
      run_to(3 + x);
      check_eq($sformatf("px_r0_x%0d", x), 32'(pixel), 32'(row0[7 - x]));
      if (x == 1) check_eq("fs_t4", 32'(frame_start), 32'd0);
    end
    run_to(642);  check_eq("va_h639", 32'(video_active), 32'd1);
    run_to(643);  check_eq("va_h640", 32'(video_active), 32'd0);
    run_to(658);  check_eq("hs_h655", 32'(hsync), 32'd1);
    run_to(659);  check_eq("hs_h656", 32'(hsync), 32'd0);
    run_to(754);  check_eq("hs_h751", 32'(hsync), 32'd0);
    run_to(755);  check_eq("hs_h752", 32'(hsync), 32'd1);
    run_to(804);  check_eq("px_r1_x1", 32'(pixel), 32'd1);
    run_to(806);  check_eq("px_r1_x3", 32'(pixel), 32'd0);
    run_to(1444); check_eq("px_blank", 32'(pixel), 32'd0);
    run_to(1458); check_eq("hs_l1_h655", 32'(hsync), 32'd1);
    run_to(1459); check_eq("hs_l1_h656", 32'(hsync), 32'd0);
    run_to(5606); check_eq("px_r7_x3", 32'(pixel), 32'd0);

    // Address generation with the buffer echoing its address.
    addr_mode = 1'b1;
    run_to(6400); check_eq("addr_blank_l7", 32'(text_addr), 32'd0);
    run_to(6401); check_eq("addr_0_8", 32'(text_addr), 32'd80);
    run_to(6409);
    check_eq("addr_8_8", 32'(text_addr), 32'd81);
    check_eq("char_8_8", 32'(char_code), 32'd80);
    run_to(7040);
    check_eq("addr_639_8", 32'(text_addr), 32'd159);
    check_eq("char_638_8", 32'(char_code), 32'd31);
    run_to(7101); check_eq("addr_h700", 32'(text_addr), 32'd0);
    addr_mode = 1'b0;

    // Single-clock reset mid-line.
    run_to(8300);
    check_eq("va_pre_rst", 32'(video_active), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 0;
    check_reset_state("mid");
    run_to(2); check_eq("mid_fs_t2", 32'(frame_start), 32'd0);
    run_to(3); check_eq("mid_fs_t3", 32'(frame_start), 32'd1);

    // pix_ce one clk in four.
    div = 4;
    pix_ce = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 0;
    check_reset_state("ce4");
    run_to(2); check_eq("ce4_fs_t2", 32'(frame_start), 32'd0);
    run_to(3); check_eq("ce4_fs_t3", 32'(frame_start), 32'd1);
    @(posedge clk);
    #1;
    check_eq("ce4_fs_narrow", 32'(frame_start), 32'd0);
    check_eq("ce4_va_hold", 32'(video_active), 32'd1);
    run_to(8); check_eq("ce4_px_x5", 32'(pixel), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("ce4_px_hold%0d", i), 32'(pixel), 32'd1);
    end
    step();
    check_eq("ce4_px_x6", 32'(pixel), 32'd0);
    run_to(658); check_eq("ce4_hs_h655", 32'(hsync), 32'd1);
    run_to(659); check_eq("ce4_hs_h656", 32'(hsync), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("ce4_hs_hold%0d", i), 32'(hsync), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
- Text-mode scan-out engine for an 80x60 character display at 640x480.
- Generates VGA timing and fetches character codes from the text buffer RAM.
- Drives the glyph ROM lookup and serialises the returned 64-bit 8x8 bitmap into a 1-bit pixel stream with matched sync.
- Sits between the text buffer (upstream) and the colour/DAC output stage (downstream); the glyph ROM hangs off it combinationally.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- COLS, 80, characters per row (H_ACTIVE/8)
- ROWS, 60, character rows (V_ACTIVE/8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- text_addr  out  13  text buffer read address, row*COLS+col
- text_data  in  7  text buffer read data, valid one pix_ce tick after text_addr
- char_code  out  7  to glyph ROM, equals text_data (combinational pass-through)
- glyph_data  in  64  from glyph ROM, combinational, same cycle as char_code
- pixel  out  1  foreground pixel
- video_active  out  1  high in the visible region
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-clk pulse when pixel (0,0) appears on outputs

Behaviour:
- Reset: hcount=0, vcount=0, all pipeline valids 0, text_addr=0, pixel=0, video_active=0, hsync=1, vsync=1, frame_start=0. Reset mid-frame restarts at (0,0); no partial-line output.
- Counters (S0):
  - hcount 0..H_total-1 (800), increments on pix_ce.
  - At 799, hcount wraps to 0 and vcount increments.
  - vcount 0..524 wraps to 0.
- S1 (registered on pix_ce):
  - text_addr = (vcount>>3)*80 + (hcount>>3), computed as (r<<6)+(r<<4)+c, 13 bits.
  - text_addr is forced to 0 when outside the active region.
  - hcount[2:0], vcount[2:0], active, hs, vs and sof are delayed alongside.
- S2: text_data arrives; char_code=text_data; glyph_data is returned combinationally; no register.
- S3 (registered on pix_ce):
  - pixel = active & glyph_data[63 - 8*vrow - hcol].
  - Row 0 (top) is bits 63:56 and the leftmost column is the MSB of each byte.
  - video_active, hsync and vsync are registered from the delayed copies.
- Latency: exactly 3 pix_ce ticks from counter value to outputs; sync and active stay aligned with pixel.
- hsync low for hcount in [656,751]; vsync low for vcount in [490,491].
- frame_start: one clk wide, asserted on the clk where S3 registers (h=0,v=0); never asserted when pix_ce is low.
- pix_ce low: every register holds, including outputs.
- pix_ce high every clk is legal (no minimum divide).
- Blanking: pixel=0 regardless of glyph_data.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Enabled:
  - Adds ports cursor_col in 7 and cursor_row in 6.
  - Adds a 5-bit frame counter, incremented at each frame_start.
  - Blink phase = counter[4] (toggles every 16 frames).
  - While phase=1 and the S3 cell equals (cursor_row, cursor_col), pixel is inverted within the active region.
  - Counter resets to 0, so the phase starts at 0.
  - Out-of-range cursor values never match.
- Disabled: no extra ports or logic; pixel is as above.

Decomposition:
- Shared package (text_video_pkg):
  - timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end)
  - GLYPH_W=8, GLYPH_H=8
  - TEXT_ADDR_W=13, CHAR_W=7
  - typedef of the pipeline stage struct (hcol, vrow, active, hs, vs, sof)
- Sub-module vga_timing: counters, raw sync/active, sof. Natural split; the pipeline and serialiser stay in the top.

Test Plan:
- Reset, then free-run pix_ce=1 -> first frame_start exactly 3 clks after reset release; hsync period 800 clks, low for 96; vsync low for 2 lines (1600 clks); 525 lines per frame.
- RAM model returns 0x41 at every address; ROM model = real glyph table -> visible row 0 of each cell = 0x3C pattern: pixels 2..5 set, 0,1,6,7 clear; row 7 all clear.
- RAM model returns the address's low 7 bits -> text_addr for pixel (x=639,y=479) equals 4799; (8,8) gives 81; blanking gives 0.
- pix_ce toggling 1-in-4 -> outputs change only on ce clks; waveform identical to the ce=1 run, stretched by 4.
- Assert rst at hcount=300, vcount=200 for 1 clk -> outputs return to reset values; next frame_start 3 ce ticks later.
- TEXT_CURSOR_EN, cursor (5,3), char 0x20 -> frames 0-15 cell dark; frames 16-31 cell x=40..47, y=24..31 all 1; other cells 0.
